// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared defaults and grant-pointer encoding for the register-file
// write-back arbiter.
package regfile_wb_arbiter_pkg;

    localparam int NREGS_DEFAULT = 16;
    localparam int AW_DEFAULT    = 4;
    localparam int DW_DEFAULT    = 32;

    typedef enum logic {
        ALU_LAST = 1'b0,
        MEM_LAST = 1'b1
    } grant_ptr_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: req[0]/gnt[0] is the ALU, req[1]/gnt[1] the
// load unit. The pointer remembers the last winner and moves only on a grant.
module rr_arbiter2
    import regfile_wb_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    grant_ptr_t ptr;
    grant_ptr_t ptr_next;

    // Grant decode; under contention the side that did not win last goes first.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (ptr == MEM_LAST) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Next pointer value follows whoever actually transferred this cycle.
    always_comb begin
        ptr_next = ptr;
        if (gnt[0]) begin
            ptr_next = ALU_LAST;
        end else if (gnt[1]) begin
            ptr_next = MEM_LAST;
        end else begin
            ptr_next = ptr;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= MEM_LAST;
        end else begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: merges ALU and load results onto one
// write port and tracks per-register outstanding claims from decode.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NREGS = NREGS_DEFAULT,
    parameter int AW    = AW_DEFAULT,
    parameter int DW    = DW_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [AW-1:0]    alu_addr,
    input  logic [DW-1:0]    alu_data,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic [AW-1:0]    mem_addr,
    input  logic [DW-1:0]    mem_data,
    input  logic             claim_valid,
    output logic             claim_ready,
    input  logic [AW-1:0]    claim_addr,
    output logic             regwBoolean,
    output logic [AW-1:0]    rwselector,
    output logic [DW-1:0]    rwdata,
    output logic [NREGS-1:0] busy_mask
);

    logic [1:0]       req;
    logic [1:0]       gnt;
    logic             wb_fire;
    logic [AW-1:0]    wb_sel;
    logic [DW-1:0]    wb_data;
    logic             claim_busy;
    logic             claim_fire;
    logic [NREGS-1:0] busy_next;

    // Masking requests with reset keeps every ready low while reset is held.
    assign req = {mem_valid & ~reset, alu_valid & ~reset};

    rr_arbiter2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .gnt   (gnt)
    );

    assign alu_ready = gnt[0];
    assign mem_ready = gnt[1];
    assign wb_fire   = gnt[0] | gnt[1];
    assign wb_sel    = gnt[0] ? alu_addr : mem_addr;
    assign wb_data   = gnt[0] ? alu_data : mem_data;

    // Busy lookup for the claimed register.
    always_comb begin
        claim_busy = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            if (claim_addr == AW'(i)) begin
                claim_busy = busy_mask[i];
            end else begin
                claim_busy = claim_busy;
            end
        end
    end

    // A same-cycle write-back to the claimed register frees it in time.
    assign claim_ready = ~reset & (~claim_busy | (wb_fire & (wb_sel == claim_addr)));
    assign claim_fire  = claim_valid & claim_ready;

    // Clear on write-back first, then set on claim so a same-edge claim wins.
    always_comb begin
        busy_next = busy_mask;
        for (int i = 0; i < NREGS; i++) begin
            if (wb_fire && (wb_sel == AW'(i))) begin
                busy_next[i] = 1'b0;
            end else begin
                busy_next[i] = busy_next[i];
            end
            if (claim_fire && (claim_addr == AW'(i))) begin
                busy_next[i] = 1'b1;
            end else begin
                busy_next[i] = busy_next[i];
            end
        end
    end

    // Registered write port and busy mask; select/data hold when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regwBoolean <= 1'b0;
            rwselector  <= {AW{1'b0}};
            rwdata      <= {DW{1'b0}};
            busy_mask   <= {NREGS{1'b0}};
        end else begin
            regwBoolean <= wb_fire;
            if (wb_fire) begin
                rwselector <= wb_sel;
                rwdata     <= wb_data;
            end else begin
                rwselector <= rwselector;
                rwdata     <= rwdata;
            end
            busy_mask <= busy_next;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: stimulus pushes expected writes
// into a scoreboard queue, a negedge monitor pops and compares them.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, mem_valid, claim_valid;
    logic        alu_ready, mem_ready, claim_ready;
    logic [3:0]  alu_addr, mem_addr, claim_addr;
    logic [31:0] alu_data, mem_data;
    logic        regwBoolean;
    logic [3:0]  rwselector;
    logic [31:0] rwdata;
    logic [15:0] busy_mask;

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] data;
        int          due;
    } wb_exp_t;

    wb_exp_t sbq[$];
    int      cyc    = 0;
    int      n_cmp  = 0;
    int      n_err  = 0;

    regfile_wb_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_addr    (alu_addr),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .claim_valid (claim_valid),
        .claim_ready (claim_ready),
        .claim_addr  (claim_addr),
        .regwBoolean (regwBoolean),
        .rwselector  (rwselector),
        .rwdata      (rwdata),
        .busy_mask   (busy_mask)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_wb(input logic [3:0] sel, input logic [31:0] data);
        wb_exp_t e;
        e.sel  = sel;
        e.data = data;
        e.due  = cyc + 1;
        sbq.push_back(e);
    endtask

    // Drive one cycle of inputs at the negedge, settle 1 time unit for checks.
    task automatic drive(input logic av, input logic [3:0] aa, input logic [31:0] ad,
                         input logic mv, input logic [3:0] ma, input logic [31:0] md,
                         input logic cv, input logic [3:0] ca);
        @(negedge clk);
        alu_valid = av; alu_addr = aa; alu_data = ad;
        mem_valid = mv; mem_addr = ma; mem_data = md;
        claim_valid = cv; claim_addr = ca;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        alu_valid = 1'b0; mem_valid = 1'b0; claim_valid = 1'b0;
        sbq.delete();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Scoreboard monitor: every write must match the queue head in its due cycle.
    initial begin
        wb_exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                    e = sbq.pop_front();
                    n_cmp++;
                    if (!(regwBoolean === 1'b1 && rwselector === e.sel && rwdata === e.data && e.due == cyc)) begin
                        n_err++;
                        $display("FAIL wb_write: got we=%0b sel=%0h data=%0h expected we=1 sel=%0h data=%0h due=%0d cycle=%0d",
                                 regwBoolean, rwselector, rwdata, e.sel, e.data, e.due, cyc);
                    end
                end else if (regwBoolean !== 1'b0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL wb_unexpected: got we=%0b sel=%0h data=%0h expected no write (cycle %0d)",
                             regwBoolean, rwselector, rwdata, cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        alu_valid = 1'b1; alu_addr = 4'h3; alu_data = 32'h1234;
        mem_valid = 1'b1; mem_addr = 4'h2; mem_data = 32'h5678;
        claim_valid = 1'b1; claim_addr = 4'h1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_we",          64'(regwBoolean), 64'd0);
        chk("rst_sel",         64'(rwselector),  64'd0);
        chk("rst_data",        64'(rwdata),      64'd0);
        chk("rst_busy",        64'(busy_mask),   64'd0);
        chk("rst_alu_ready",   64'(alu_ready),   64'd0);
        chk("rst_mem_ready",   64'(mem_ready),   64'd0);
        chk("rst_claim_ready", 64'(claim_ready), 64'd0);
        alu_valid = 1'b0; mem_valid = 1'b0; claim_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Single ALU request: granted the same cycle, written one cycle later.
        drive(1'b1, 4'h3, 32'hDEADBEEF, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0);
        chk("single_alu_ready", 64'(alu_ready), 64'd1);
        chk("single_mem_ready", 64'(mem_ready), 64'd0);
        expect_wb(4'h3, 32'hDEADBEEF);
        idle();
        idle();
        chk("hold_we",   64'(regwBoolean), 64'd0);
        chk("hold_sel",  64'(rwselector),  64'd3);
        chk("hold_data", 64'(rwdata),      64'hDEADBEEF);

        // Contention after reset alternates ALU, MEM, ALU, MEM.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'h1, 32'hA1, 1'b1, 4'h2, 32'hB2, 1'b0, 4'h0);
            chk($sformatf("rr_alu_ready_%0d", i), 64'(alu_ready), (i % 2 == 0) ? 64'd1 : 64'd0);
            chk($sformatf("rr_mem_ready_%0d", i), 64'(mem_ready), (i % 2 == 0) ? 64'd0 : 64'd1);
            if (i % 2 == 0) expect_wb(4'h1, 32'hA1);
            else            expect_wb(4'h2, 32'hB2);
        end
        idle();

        // Claim tracking on r5.
        drive(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 4'h5);
        chk("claim1_ready", 64'(claim_ready), 64'd1);
        idle();
        chk("claim1_busy", 64'(busy_mask), 64'h0020);
        drive(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 4'h5);
        chk("claim2_ready", 64'(claim_ready), 64'd0);
        drive(1'b0, 4'h0, 32'h0, 1'b1, 4'h5, 32'h55, 1'b0, 4'h0);
        chk("clr_mem_ready", 64'(mem_ready), 64'd1);
        expect_wb(4'h5, 32'h55);
        idle();
        chk("clr_busy", 64'(busy_mask), 64'h0000);
        drive(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 4'h5);
        idle();
        chk("reclaim_busy", 64'(busy_mask), 64'h0020);
        drive(1'b0, 4'h0, 32'h0, 1'b1, 4'h5, 32'h66, 1'b1, 4'h5);
        chk("same_edge_mem_ready",   64'(mem_ready),   64'd1);
        chk("same_edge_claim_ready", 64'(claim_ready), 64'd1);
        expect_wb(4'h5, 32'h66);
        idle();
        chk("same_edge_busy", 64'(busy_mask), 64'h0020);

        // Write-back to an unclaimed register still commits, mask untouched.
        drive(1'b0, 4'h0, 32'h0, 1'b1, 4'h9, 32'h99, 1'b0, 4'h0);
        chk("unclaimed_mem_ready", 64'(mem_ready), 64'd1);
        expect_wb(4'h9, 32'h99);
        idle();
        chk("unclaimed_busy", 64'(busy_mask), 64'h0020);

        // Both requesters target r7: ALU first, then MEM.
        do_reset();
        drive(1'b1, 4'h7, 32'h11, 1'b1, 4'h7, 32'h22, 1'b0, 4'h0);
        chk("r7_alu_ready", 64'(alu_ready), 64'd1);
        chk("r7_mem_ready", 64'(mem_ready), 64'd0);
        expect_wb(4'h7, 32'h11);
        drive(1'b0, 4'h0, 32'h0, 1'b1, 4'h7, 32'h22, 1'b0, 4'h0);
        chk("r7_mem_ready2", 64'(mem_ready), 64'd1);
        expect_wb(4'h7, 32'h22);
        idle();
        idle();

        // Reset mid-cycle after a grant discards the pending write.
        drive(1'b1, 4'h6, 32'h77, 1'b0, 4'h0, 32'h0, 1'b1, 4'h4);
        chk("rst_mid_alu_ready", 64'(alu_ready), 64'd1);
        @(posedge clk);
        #2;
        chk("rst_mid_we_before", 64'(regwBoolean), 64'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid_we",        64'(regwBoolean), 64'd0);
        chk("rst_mid_busy",      64'(busy_mask),   64'd0);
        chk("rst_mid_data",      64'(rwdata),      64'd0);
        chk("rst_mid_alu_ready", 64'(alu_ready),   64'd0);
        @(negedge clk);
        alu_valid = 1'b0; claim_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        idle();
        chk("rst_after_we",   64'(regwBoolean), 64'd0);
        chk("rst_after_busy", 64'(busy_mask),   64'd0);
        idle();
        idle();

        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter NREGS, default 16, number of architectural registers.
REQ-002 SHALL have parameter AW, default 4, register-select width.
REQ-003 SHALL have parameter DW, default 32, write-data width.
REQ-004 clk  input  1  single clock; all state on posedge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 alu_valid / alu_ready  input / output  1 / 1  ALU write-back handshake.
REQ-007 alu_addr / alu_data  input  AW / DW  ALU destination register and result.
REQ-008 mem_valid / mem_ready  input / output  1 / 1  load write-back handshake.
REQ-009 mem_addr / mem_data  input  AW / DW  load destination register and data.
REQ-010 claim_valid / claim_ready  input / output  1 / 1  decode reserves a destination register.
REQ-011 claim_addr  input  AW  register being reserved.
REQ-012 regwBoolean  output  1  register-file write enable.
REQ-013 rwselector / rwdata  output  AW / DW  register-file write select and data.
REQ-014 busy_mask  output  NREGS  bit i set while register i has an outstanding claim.

Function
REQ-015 A transfer SHALL occur on a requester when valid and ready are both high at a posedge.
REQ-016 ready SHALL be combinational from valid inputs and the pointer; at most one ready high per cycle; ready low when that valid is low.
REQ-017 Single valid requester SHALL be granted the same cycle.
REQ-018 Both valid: SHALL grant the requester not granted last; the 1-bit pointer records the last grant (states ALU_LAST, MEM_LAST) and updates only on a transfer.
REQ-019 Pointer SHALL reset to MEM_LAST, so the first contention grants ALU.
REQ-020 regwBoolean, rwselector, rwdata SHALL be registered: the granted transfer appears on the outputs exactly one cycle later for exactly one cycle; regwBoolean low otherwise.
REQ-021 rwselector/rwdata SHALL hold previous values when regwBoolean is low.
REQ-022 Sustained throughput SHALL be one write per cycle; a requester waiting under contention is granted within 2 cycles.
REQ-023 Same-address writes from both requesters SHALL both commit, in grant order; the later one wins in the register file.
REQ-024 claim_ready SHALL be high when busy_mask[claim_addr] is 0, or when a transfer to claim_addr occurs that cycle.
REQ-025 Claim handshake SHALL set busy_mask[claim_addr] at the posedge.
REQ-026 A write-back transfer SHALL clear busy_mask[addr] at the transfer posedge.
REQ-027 Claim and clear of the same register on the same edge SHALL leave the bit set.
REQ-028 A write-back to a register whose busy bit is clear SHALL still be written, with busy_mask unchanged.
REQ-029 busy_mask SHALL be a registered output.

Reset
REQ-030 Reset assertion SHALL immediately force regwBoolean=0, rwselector=0, rwdata=0, busy_mask=0, pointer=MEM_LAST, independent of clk.
REQ-031 Reset mid-operation SHALL discard any not-yet-emitted write.
REQ-032 While reset is high, all ready outputs SHALL be 0.
REQ-033 The first grant SHALL be possible on the first posedge after deassertion.

Structure
REQ-034 A shared package SHALL hold NREGS, AW, DW defaults and the grant-pointer enum (ALU_LAST, MEM_LAST).
REQ-035 Round-robin grant logic SHALL be one sub-module, rr_arbiter2, with inputs req[1:0] and outputs gnt[1:0]; the scoreboard stays inline.

Verification
REQ-036 Bench SHALL check: alu_valid=1, addr=3, data=0xDEADBEEF alone at cycle N -> alu_ready=1 at N; regwBoolean=1, rwselector=3, rwdata=0xDEADBEEF at N+1 only.
REQ-037 Bench SHALL check: after reset, both valid for 4 cycles (ALU addr 1, MEM addr 2) -> grants ALU, MEM, ALU, MEM; writes 1, 2, 1, 2 back-to-back.
REQ-038 Bench SHALL check: claim r5 -> busy_mask=0x0020; second claim r5 -> claim_ready=0; MEM write r5 -> bit clears; a re-claim of r5 on the same edge keeps busy_mask=0x0020.
REQ-039 Bench SHALL check: both requesters write r7 (ALU 0x11, MEM 0x22) after reset -> 0x11 emitted, then 0x22.
REQ-040 Bench SHALL check: reset asserted mid-cycle after a grant -> regwBoolean drops immediately, next cycle shows no write, busy_mask=0.
REQ-041 Bench SHALL check: MEM write r9 while busy_mask[9]=0 -> write emitted, busy_mask unchanged.
